alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Registered execute-stage ALU that sits directly downstream of `alu_control`. It consumes the 3-bit `ALUControl` code together with the two register-file operands and produces `ALUResult` and `Zero` for the branch and write-back logic. Add, sub, and, or and slt complete in one cycle. The `mul` code (`ALUControl` = 101, from funct 011100) runs a 32-step shift-add multiplier behind a start/busy/done handshake.

## Interface
- `WIDTH`, 32: operand and result width. The multiplier step count equals `WIDTH`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `Start`  in  1  request; sampled only when `Busy`=0
- `ALUControl`  in  3  operation: 000 and, 001 or, 010 add, 100 sub, 110 slt, 101 mul; any other code executes as add
- `SrcA`  in  WIDTH  operand A
- `SrcB`  in  WIDTH  operand B
- `ALUResult`  out  WIDTH  registered result; holds its value until the next `Done`
- `Zero`  out  1  registered; 1 when `ALUResult`==0
- `Busy`  out  1  multiply in progress; `Start` is ignored while it is high
- `Done`  out  1  one-cycle pulse; `ALUResult` and `Zero` are valid in the same cycle

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: multiply in progress.
  - DONE: result just presented; a new request may be accepted.
- Acceptance: `Start`=1 at a rising edge while in IDLE or DONE latches `SrcA`, `SrcB` and `ALUControl`.
- Single-cycle ops (from IDLE or DONE, with `Start`=1):
  - The result is computed and registered on the accepting edge; the FSM moves to DONE.
  - add/sub wrap modulo 2^WIDTH. There is no overflow flag.
  - slt is a signed compare; the result is zero-extended 1 or 0.
  - and/or are bitwise.
- mul (from IDLE or DONE, with `Start`=1):
  - On the accepting edge: multiplicand := `SrcA`, multiplier := `SrcB`, accumulator := 0, step counter := 0; the FSM moves to MUL.
  - Each cycle in MUL:
    - if multiplier[0], accumulator += multiplicand;
    - multiplicand <<= 1, multiplier >>= 1, counter++.
  - After the step with counter == WIDTH-1: `ALUResult` := accumulator (low WIDTH bits) and the FSM moves to DONE.
  - There is no early termination; a zero operand still takes WIDTH steps.
- DONE:
  - With `Start`=0, the FSM returns to IDLE.
  - With `Start`=1, the new request is accepted (back-to-back issue).
- `Start` during MUL is dropped. It is not queued.
- Input changes on `SrcA`, `SrcB` or `ALUControl` after acceptance have no effect on the operation in flight.

## Timing
- Reset values: state IDLE, `ALUResult`=0, `Zero`=1, `Busy`=0, `Done`=0, counter 0.
- Single-cycle op accepted at edge N: `Done`=1 and the result are visible after edge N; latency is 1 cycle.
- mul accepted at edge N:
  - `Busy`=1 from after edge N through after edge N+31.
  - `Done`=1 and the result are visible after edge N+32; latency is WIDTH+1 cycles.
- `Done` is high for exactly one cycle per accepted request. `Busy` and `Done` are never high together.
- `Zero` updates only on the edge that raises `Done`.
- `rst_n` low mid-multiply:
  - The FSM immediately returns to IDLE and the partial product is discarded.
  - No `Done` is issued.
  - Outputs take their reset values.
- Maximum throughput is one single-cycle op per clock, via DONE to DONE.

## Configuration
- `ALU_MUL_EN` defined: the multiplier datapath, MUL state and counter are built, and code 101 behaves as described above.
- `ALU_MUL_EN` undefined: the multiplier logic is omitted. Code 101 completes as a single-cycle op with `ALUResult`=0 and `Zero`=1. `Busy` is tied to 0.

## Test plan
- Reset, then add: `SrcA`=5, `SrcB`=7, `ALUControl`=010, `Start` at edge N. Required: `ALUResult`=12, `Zero`=0 and a one-cycle `Done` after edge N; `ALUResult` holds 12 afterward.
- Sub back-to-back, then slt: 3−3 followed on the next edge by slt(0xFFFFFFFF, 1).
  - The sub gives `ALUResult`=0, `Zero`=1 and `Done`.
  - The slt gives `ALUResult`=1, `Done` on consecutive cycles.
- mul: 0x00010003 × 0x00000005 at edge N. Required:
  - `Busy` high for 32 cycles;
  - `Done` after edge N+32;
  - `ALUResult`=0x0005000F.
- Overflow wrap: add 0xFFFFFFFF+1 gives 0 with `Zero`=1. mul 0x80000000×2 gives 0 after 33 cycles.
- `Start` with add 1+1 pulsed mid-multiply is ignored: only the mul `Done` appears and no extra `Done` follows.
- `rst_n` low 10 cycles into a mul: `Busy`=0, `ALUResult`=0, `Zero`=1 immediately and no `Done`; a subsequent add of 2+2 gives 4.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the issue logic and alu_exec_unit.
// The master drives the operation; the slave returns the result and the handshake status.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, ALUControl, SrcA, SrcB,
        input  ALUResult, Zero, Busy, Done
    );

    modport slave (
        input  Start, ALUControl, SrcA, SrcB,
        output ALUResult, Zero, Busy, Done
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU: single-cycle and/or/add/sub/slt, plus an optional
// WIDTH-step shift-add multiplier built only when ALU_MUL_EN is defined.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpSlt = 3'b110;
    localparam logic [2:0] OpMul = 3'b101;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             done_q;
    logic [WIDTH-1:0] op_res;

    always_comb begin
        op_res = bus.SrcA + bus.SrcB;
        case (bus.ALUControl)
            OpAnd:   op_res = bus.SrcA & bus.SrcB;
            OpOr:    op_res = bus.SrcA | bus.SrcB;
            OpAdd:   op_res = bus.SrcA + bus.SrcB;
            OpSub:   op_res = bus.SrcA - bus.SrcB;
            OpSlt:   op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            // Without the multiplier, mul retires immediately with a zero result.
            OpMul:   op_res = '0;
            default: op_res = bus.SrcA + bus.SrcB;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    logic             busy_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] acc_step;

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign bus.Busy = busy_q;
`else
    assign bus.Busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (bus.Start) begin
`ifdef ALU_MUL_EN
                        if (bus.ALUControl == OpMul) begin
                            mcand_q  <= bus.SrcA;
                            mplier_q <= bus.SrcB;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= StMul;
                        end else
`endif
                        begin
                            result_q <= op_res;
                            zero_q   <= (op_res == '0);
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
`ifdef ALU_MUL_EN
                StMul: begin
                    // Start is deliberately not looked at here: requests during a multiply drop.
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        result_q <= acc_step;
                        zero_q   <= (acc_step == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StDone;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Done      = done_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expectations follow ALU_MUL_EN when defined.
module tb_alu_exec_unit;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Start      = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.Start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One single-cycle op; result must appear right after the accepting edge.
    task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        check_eq({tag, "_res"},  bus.ALUResult, exp);
        check_eq({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, exp == 32'd0});
        check_eq({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
    endtask

`ifdef ALU_MUL_EN
    // Multiply with optional mid-flight Start pulse (pulse_at = 0 disables it).
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int pulse_at);
        int cycles;
        int busy_cnt;
        int both;
        int extra;
        issue(3'b101, a, b);
        check_eq({tag, "_busy0"}, {31'd0, bus.Busy}, 32'd1);
        check_eq({tag, "_done0"}, {31'd0, bus.Done}, 32'd0);
        bus.Start = 1'b0;
        bus.SrcA  = 32'hDEAD_BEEF;
        bus.SrcB  = 32'h1234_5678;
        cycles    = 0;
        busy_cnt  = 1;
        both      = 0;
        while (cycles < 40) begin
            if (pulse_at != 0 && cycles == pulse_at) begin
                bus.Start      = 1'b1;
                bus.ALUControl = 3'b010;
                bus.SrcA       = 32'd1;
                bus.SrcB       = 32'd1;
            end
            @(posedge clk);
            #1;
            bus.Start = 1'b0;
            cycles++;
            if (bus.Busy) busy_cnt++;
            if (bus.Busy && bus.Done) both++;
            if (bus.Done) break;
        end
        check_eq({tag, "_lat"},  cycles, 32'd32);
        check_eq({tag, "_busyn"}, busy_cnt, 32'd32);
        check_eq({tag, "_both"}, both, 32'd0);
        check_eq({tag, "_res"},  bus.ALUResult, exp);
        check_eq({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, exp == 32'd0});
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.Done) extra++;
        end
        check_eq({tag, "_extra"}, extra, 32'd0);
        check_eq({tag, "_hold"}, bus.ALUResult, exp);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        bus.Start      = 1'b0;
        bus.ALUControl = 3'b000;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_res",  bus.ALUResult, 32'd0);
        check_eq("rst_zero", {31'd0, bus.Zero}, 32'd1);
        check_eq("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single("add", 3'b010, 32'd5, 32'd7, 32'd12);
        @(negedge clk);
        bus.Start = 1'b0;
        bus.SrcA  = 32'd100;
        @(posedge clk);
        #1;
        check_eq("add_pulse", {31'd0, bus.Done}, 32'd0);
        check_eq("add_hold",  bus.ALUResult, 32'd12);

        // Back-to-back: sub then slt on consecutive edges.
        single("sub", 3'b100, 32'd3, 32'd3, 32'd0);
        single("slt", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single("slt_f", 3'b110, 32'd1, 32'hFFFF_FFFF, 32'd0);
        single("and", 3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        single("or",  3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        single("dflt", 3'b011, 32'd2, 32'd3, 32'd5);
        single("wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("subw", 3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF);
        idle_cycle();
        check_eq("idle_done", {31'd0, bus.Done}, 32'd0);

`ifdef ALU_MUL_EN
        run_mul("mul", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 0);
        run_mul("mulw", 32'h8000_0000, 32'd2, 32'd0, 0);
        run_mul("mulp", 32'd7, 32'd6, 32'd42, 10);
`else
        single("mul0", 3'b101, 32'h0001_0003, 32'h0000_0005, 32'd0);
        idle_cycle();
        check_eq("mul0_done", {31'd0, bus.Done}, 32'd0);
`endif

        // Reset in the middle of work: outputs must drop immediately.
        single("pre", 3'b010, 32'd4, 32'd5, 32'd9);
`ifdef ALU_MUL_EN
        issue(3'b101, 32'd3, 32'd4);
        bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
`else
        bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
`endif
        rst_n = 1'b0;
        #1;
        check_eq("mrst_busy", {31'd0, bus.Busy}, 32'd0);
        check_eq("mrst_res",  bus.ALUResult, 32'd0);
        check_eq("mrst_zero", {31'd0, bus.Zero}, 32'd1);
        check_eq("mrst_done", {31'd0, bus.Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dn;
            dn = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (bus.Done) dn++;
            end
            check_eq("mrst_nodone", dn, 32'd0);
        end
        single("post", 3'b010, 32'd2, 32'd2, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
